// File: rtl/mq_sb_pkg.sv
// mq_sb_pkg: shared constants and helpers for the multi-queue scoreboard.
package mq_sb_pkg;
  localparam int ERR_CNT_W = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/multi_queue_scoreboard_if.sv
// multi_queue_scoreboard_if: DUT-observation bus and scoreboard status.
// MQ_SB_FIRST_ERR_CAPTURE_EN adds the first-data-mismatch capture signals.
interface multi_queue_scoreboard_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NUM_FIFOS = 2
);
  logic push, pop;
  logic [$clog2(NUM_FIFOS)-1:0] push_sel, pop_sel;
  logic [WIDTH-1:0] data_in, dut_data_out;
  logic [NUM_FIFOS-1:0] dut_empty, sb_empty;
  logic dut_full, sb_full;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic mismatch, err, overflow, underflow;
  logic [15:0] err_cnt;
`ifdef MQ_SB_FIRST_ERR_CAPTURE_EN
  logic [$clog2(NUM_FIFOS)-1:0] first_err_chan;
  logic [WIDTH-1:0] first_err_exp, first_err_act;
  modport master (
    output push, pop, push_sel, pop_sel, data_in, dut_data_out, dut_empty, dut_full,
    input sb_empty, sb_full, occupancy, mismatch, err, err_cnt, overflow, underflow,
    input first_err_chan, first_err_exp, first_err_act
  );
  modport slave (
    input push, pop, push_sel, pop_sel, data_in, dut_data_out, dut_empty, dut_full,
    output sb_empty, sb_full, occupancy, mismatch, err, err_cnt, overflow, underflow,
    output first_err_chan, first_err_exp, first_err_act
  );
`else
  modport master (
    output push, pop, push_sel, pop_sel, data_in, dut_data_out, dut_empty, dut_full,
    input sb_empty, sb_full, occupancy, mismatch, err, err_cnt, overflow, underflow
  );
  modport slave (
    input push, pop, push_sel, pop_sel, data_in, dut_data_out, dut_empty, dut_full,
    output sb_empty, sb_full, occupancy, mismatch, err, err_cnt, overflow, underflow
  );
`endif
endinterface

// File: rtl/sb_channel_queue.sv
// sb_channel_queue: one circular FIFO channel of the scoreboard model.
module sb_channel_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push && !rst) mem[wp] <= din;
  assign head = mem[rp];
endmodule

// File: rtl/multi_queue_scoreboard.sv
// multi_queue_scoreboard: shared-capacity per-channel FIFO model checking a DUT.
// MQ_SB_FIRST_ERR_CAPTURE_EN latches channel/expected/actual of the first data mismatch.
module multi_queue_scoreboard
  import mq_sb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NUM_FIFOS = 2
) (
  input logic clk,
  input logic rst,
  multi_queue_scoreboard_if.slave bus
);
  localparam int SW = $clog2(NUM_FIFOS);
  localparam int OW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] heads [NUM_FIFOS];
  logic [OW-1:0] counts [NUM_FIFOS];
  logic [NUM_FIFOS-1:0] empty_v;
  logic [OW-1:0] occ;
  logic [ERR_CNT_W-1:0] cnt;
  logic full, push_ok, pop_ok, data_bad, mis_n, ovf_n, unf_n, mis_q, ovf_q, unf_q, err_q;
  logic [WIDTH-1:0] pop_head;
  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_ch
    sb_channel_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_q (
      .clk(clk),
      .rst(rst),
      .push(push_ok && bus.push_sel == SW'(i)),
      .pop(pop_ok && bus.pop_sel == SW'(i)),
      .din(bus.data_in),
      .head(heads[i]),
      .count(counts[i])
    );
    assign empty_v[i] = counts[i] == '0;
  end
  // Acceptance uses registered state only: a same-cycle pop never frees room for a push.
  always_comb begin
    full = occ == OW'(DEPTH);
    push_ok = bus.push && !full && 32'(bus.push_sel) < NUM_FIFOS;
    pop_ok = bus.pop && 32'(bus.pop_sel) < NUM_FIFOS && !empty_v[bus.pop_sel];
    pop_head = heads[bus.pop_sel];
    data_bad = pop_ok && bus.dut_data_out != pop_head;
    mis_n = data_bad || bus.dut_empty != empty_v || bus.dut_full != full;
    ovf_n = bus.push && !push_ok;
    unf_n = bus.pop && !pop_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      {mis_q, ovf_q, unf_q, err_q} <= '0;
      cnt <= '0;
    end else begin
      occ <= occ + OW'(push_ok) - OW'(pop_ok);
      mis_q <= mis_n;
      ovf_q <= ovf_n;
      unf_q <= unf_n;
      err_q <= err_q || mis_n || ovf_n || unf_n;
      cnt <= (mis_n || ovf_n || unf_n) ? sat_inc(cnt) : cnt;
    end
  end
  assign bus.sb_empty = empty_v;
  assign bus.sb_full = full;
  assign bus.occupancy = occ;
  assign bus.mismatch = mis_q;
  assign bus.overflow = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.err = err_q;
  assign bus.err_cnt = cnt;
`ifdef MQ_SB_FIRST_ERR_CAPTURE_EN
  logic cap_done;
  logic [SW-1:0] cap_chan;
  logic [WIDTH-1:0] cap_exp, cap_act;
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_done <= 1'b0;
      cap_chan <= '0;
      cap_exp <= '0;
      cap_act <= '0;
    end else if (data_bad && !cap_done) begin
      cap_done <= 1'b1;
      cap_chan <= bus.pop_sel;
      cap_exp <= pop_head;
      cap_act <= bus.dut_data_out;
    end
  end
  assign bus.first_err_chan = cap_chan;
  assign bus.first_err_exp = cap_exp;
  assign bus.first_err_act = cap_act;
`endif
endmodule

// File: doc/multi_queue_scoreboard.md
MULTI_QUEUE_SCOREBOARD -- requirements
Module: multi_queue_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter DEPTH, default 4, total shared entries across all channels (power of two, >=2).
REQ-003 SHALL have parameter NUM_FIFOS, default 2, channel count (>=2).
REQ-004 SHALL have clk  input  1  sole clock, all state on posedge.
REQ-005 SHALL have rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have push  input  1  DUT push request; pop  input  1  DUT pop request.
REQ-007 SHALL have push_sel, pop_sel  input  $clog2(NUM_FIFOS)  channel selects.
REQ-008 SHALL have data_in  input  WIDTH  pushed word.
REQ-009 SHALL have dut_data_out  input  WIDTH  DUT head word, valid combinationally with pop.
REQ-010 SHALL have dut_empty  input  NUM_FIFOS  and dut_full  input  1, DUT status.
REQ-011 SHALL have sb_empty  output  NUM_FIFOS  and sb_full  output  1, model status.
REQ-012 SHALL have occupancy  output  $clog2(DEPTH+1)  total model entries.
REQ-013 SHALL have mismatch  output  1  one-cycle pulse; err  output  1  sticky; err_cnt  output  16  saturating count.
REQ-014 SHALL have overflow, underflow  output  1  one-cycle illegal-op pulses.

Function
REQ-015 Model SHALL keep one FIFO-ordered queue per channel, each DEPTH deep; combined occupancy SHALL never exceed DEPTH.
REQ-016 sb_full SHALL equal (occupancy == DEPTH); sb_empty[i] SHALL be high iff channel i holds zero entries.
REQ-017 Push SHALL be accepted iff push && !sb_full; rejected push SHALL leave state unchanged and pulse overflow next cycle, even if a pop occurs the same cycle.
REQ-018 Pop SHALL be accepted iff pop && !sb_empty[pop_sel]; rejected pop SHALL pulse underflow next cycle; no push-to-pop bypass on an empty channel.
REQ-019 On accepted pop, dut_data_out SHALL be compared with the model head of pop_sel; inequality SHALL pulse mismatch the following cycle.
REQ-020 Every non-reset cycle, dut_empty != sb_empty or dut_full != sb_full SHALL pulse mismatch the following cycle.
REQ-021 Simultaneous accepted push and pop (same or different channel) SHALL both take effect; occupancy unchanged.
REQ-022 Per-channel read/write pointers SHALL wrap modulo DEPTH.
REQ-023 Any mismatch, overflow or underflow pulse SHALL set err and increment err_cnt by one, saturating at 16'hFFFF.

Reset
REQ-024 While rst high: all queues empty, occupancy=0, sb_empty all ones, sb_full=0, mismatch/overflow/underflow/err=0, err_cnt=0; inputs ignored.
REQ-025 rst asserted mid-operation SHALL discard all contents on that edge; first cycle after reset SHALL perform no comparison on stale data.

Configuration
REQ-026 Macro MQ_SB_FIRST_ERR_CAPTURE_EN defined: SHALL add outputs first_err_chan ($clog2(NUM_FIFOS)), first_err_exp (WIDTH), first_err_act (WIDTH), latched on the first data mismatch after reset and held until reset.
REQ-027 Macro undefined: those ports and registers SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package mq_sb_pkg SHALL hold the error-counter width constant (16) and the saturating-max constant.
REQ-029 One sub-module sb_channel_queue (single circular queue: push, pop, head, count) SHALL be instantiated NUM_FIFOS times via generate.

Verification
REQ-030 Reset, push 8'hA1 ch0, 8'hB2 ch1, pop ch0 with dut_data_out=8'hA1 -> no mismatch, occupancy 2->1.
REQ-031 Pop ch1 with dut_data_out=8'h00 while head is 8'hB2 -> mismatch pulse, err=1, err_cnt=1 (capture: chan=1, exp=B2, act=00).
REQ-032 Fill DEPTH=4 entries on ch0, fifth push -> overflow pulse, sb_full=1, contents unchanged.
REQ-033 Pop ch1 while empty with simultaneous push ch1 -> underflow pulse, ch1 count=1.
REQ-034 Drive dut_full=1 with occupancy 3 -> mismatch next cycle; rst mid-fill -> all outputs to reset values next cycle.
REQ-035 Push/pop 10 words through ch0 with dut_data_out correct -> pointer wrap, zero errors, err_cnt=0.
